// File: rtl/powlib_dpram_wrarb_if.sv
// Requester-side handshake and dpram write-port bundle for powlib_dpram_wrarb.
// The arbiter uses the slave modport; the requesters/dpram side uses master.
interface powlib_dpram_wrarb_if #(
    parameter int W    = 16,
    parameter int WIDX = 3,
    parameter int N    = 4,
    parameter int GW   = 2
);
    logic [N-1:0]      reqvld;
    logic [N*WIDX-1:0] reqidx;
    logic [N*W-1:0]    reqdata;
    logic [N-1:0]      reqlck;
    logic [N-1:0]      reqrdy;
    logic [WIDX-1:0]   wridx;
    logic [W-1:0]      wrdata;
    logic              wrvld;
    logic [GW-1:0]     gntidx;

    modport master (
        output reqvld, reqidx, reqdata, reqlck,
        input  reqrdy, wridx, wrdata, wrvld, gntidx
    );

    modport slave (
        input  reqvld, reqidx, reqdata, reqlck,
        output reqrdy, wridx, wrdata, wrvld, gntidx
    );
endinterface

// File: rtl/powlib_dpram_wrarb.sv
// Round-robin arbiter sharing one powlib_dpram write port among N requesters,
// with bounded lock bursts so one requester's beats land back-to-back.
module powlib_dpram_wrarb #(
    parameter int W      = 16,
    parameter int D      = 8,
    parameter int WIDX   = (D > 1) ? $clog2(D) : 1,
    parameter int N      = 4,
    parameter int MAXLCK = 8,
    parameter int GW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    powlib_dpram_wrarb_if.slave bus
);
    localparam int CW = (MAXLCK > 0) ? $clog2(MAXLCK + 1) : 1;
    localparam logic [GW-1:0] PTR_RST = GW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   own_r;
    logic [GW-1:0]   ptr_r;
    logic [CW-1:0]   lckcnt_r;
    logic [GW-1:0]   gnt_r;
    logic [WIDX-1:0] wridx_r;
    logic [W-1:0]    wrdata_r;
    logic            wrvld_r;

    logic [GW-1:0]   sel_s;
    logic            hit_s;
    logic            acc_s;
    logic            lck_s;
    logic            last_s;
    logic [N-1:0]    rdy_s;
    int              cand_s;

    // Candidate selection: the lock owner only, otherwise first valid after ptr.
    always_comb begin
        sel_s  = '0;
        hit_s  = 1'b0;
        cand_s = 0;
        if (state_r == ST_LOCK) begin
            sel_s = own_r;
            hit_s = bus.reqvld[own_r];
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand_s = (int'(ptr_r) + k) % N;
                if (!hit_s && bus.reqvld[GW'(cand_s)]) begin
                    hit_s = 1'b1;
                    sel_s = GW'(cand_s);
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    // One-hot ready, suppressed while reset is asserted.
    always_comb begin
        rdy_s = '0;
        if (hit_s && !rst) begin
            rdy_s[sel_s] = 1'b1;
        end else begin
            rdy_s = '0;
        end
    end

    assign acc_s  = hit_s & ~rst;
    assign lck_s  = bus.reqlck[sel_s];
    // A locked beat closes the burst when lock drops or the beat count hits the cap.
    assign last_s = ~lck_s |
                    ((MAXLCK != 0) &&
                     (({1'b0, lckcnt_r} + (CW+1)'(1)) == (CW+1)'(MAXLCK)));

    // Write-port registers, round-robin pointer and lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            own_r    <= '0;
            ptr_r    <= PTR_RST;
            lckcnt_r <= '0;
            wrvld_r  <= 1'b0;
            wridx_r  <= '0;
            wrdata_r <= '0;
            gnt_r    <= '0;
        end else begin
            wrvld_r <= acc_s;
            if (acc_s) begin
                wridx_r  <= bus.reqidx[WIDX*sel_s +: WIDX];
                wrdata_r <= bus.reqdata[W*sel_s +: W];
                gnt_r    <= sel_s;
                ptr_r    <= sel_s;
                case (state_r)
                    ST_IDLE: begin
                        if (lck_s && (MAXLCK != 1)) begin
                            state_r  <= ST_LOCK;
                            own_r    <= sel_s;
                            lckcnt_r <= CW'(1);
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end
                    ST_LOCK: begin
                        if (last_s) begin
                            state_r  <= ST_IDLE;
                            lckcnt_r <= '0;
                        end else if (MAXLCK != 0) begin
                            lckcnt_r <= lckcnt_r + CW'(1);
                        end else begin
                            lckcnt_r <= lckcnt_r;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        lckcnt_r <= '0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.reqrdy = rdy_s;
    assign bus.wridx  = wridx_r;
    assign bus.wrdata = wrdata_r;
    assign bus.wrvld  = wrvld_r;
    assign bus.gntidx = gnt_r;
endmodule
